fetch_unit: RTL

Instruction-fetch stage that produces the per-cycle instruction and its PC for the IF/ID pipeline register. It owns the program counter and a variable-latency request/ready port to instruction memory. It absorbs hazard-unit stalls with a one-entry skid buffer and redirects on taken branches. It drives `instruction`, `currPC`, `pc_plus4` and `IF_ID_flush`, which is asserted whenever IF/ID must capture a bubble.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 49 ++++
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   ADDR_W   - program-counter / memory-address width
//   INSTR_W  - instruction word width
//   PC_INC   - sequential fetch stride in bytes
//   fetch_state_t - request-port FSM states
//   fetch_entry_t - one captured fetch result {instr, pc, valid}
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } fetch_entry_t;

  // Sequential successor address; wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register that catches a fetch response
// arriving while the output slot is occupied and stalled.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset (clears the valid bit)
//   i_load   - capture i_entry
//   i_entry  - entry to capture
//   i_unload - entry consumed by the output slot
//   i_clear  - discard the entry (redirect); wins over load/unload
//   o_entry  - current contents
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  fetch_entry_t i_entry,
  input  logic         i_unload,
  input  logic         i_clear,
  output fetch_entry_t o_entry
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_entry.valid;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while r_valid is set.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_instr <= i_entry.instr;
      r_pc    <= i_entry.pc;
    end
  end

  assign o_entry = '{instr: r_instr, pc: r_pc, valid: r_valid};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, drives a request/ready instruction-memory port, absorbs
// stalls with a one-entry skid buffer and redirects on taken branches.
// Ports:
//   clk, reset (async, active-low)
//   stall                  - hold current outputs unchanged
//   br_taken, br_target    - redirect request and address
//   imem_req, imem_addr    - fetch request (held stable until transfer)
//   imem_ready, imem_rdata - response handshake and data
//   instruction, currPC, pc_plus4 - output slot contents
//   IF_ID_flush            - IF/ID must capture a bubble
// Optional feature macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_fetches (accepted, non-dropped transfers) and
//   perf_bubbles (cycles with IF_ID_flush high).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  currPC,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               IF_ID_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetches,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc_q, w_pc_nxt;
  logic [ADDR_W-1:0]  r_addr_q, w_addr_nxt;

  logic               r_valid_q;
  logic [INSTR_W-1:0] r_instr_q;
  logic [ADDR_W-1:0]  r_cpc_q;
  logic [ADDR_W-1:0]  r_pc4_q;

  logic               w_xfer;
  logic               w_accept;
  logic               w_slot_free;
  logic               w_to_slot;
  logic               w_to_skid;
  logic               w_unload;
  fetch_entry_t       w_skid_in;
  fetch_entry_t       w_skid;

  assign imem_req  = (r_state == BUSY) || (r_state == DRAIN);
  assign imem_addr = r_addr_q;

  assign w_xfer      = imem_req && imem_ready;
  // Only a BUSY transfer without a simultaneous redirect carries live data.
  assign w_accept    = w_xfer && (r_state == BUSY) && !br_taken;
  assign w_slot_free = !r_valid_q || !stall;
  assign w_to_slot   = w_accept && w_slot_free;
  assign w_to_skid   = w_accept && !w_slot_free;
  assign w_unload    = !stall && w_skid.valid && !br_taken;
  assign w_skid_in   = '{instr: imem_rdata, pc: r_addr_q, valid: 1'b1};

  fetch_skid_buf u_skid (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_load   (w_to_skid),
    .i_entry  (w_skid_in),
    .i_unload (w_unload),
    .i_clear  (br_taken),
    .o_entry  (w_skid)
  );

  // ---- request FSM: state, issue address, next PC ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pc_q   <= RESET_PC;
      r_addr_q <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_pc_q   <= w_pc_nxt;
      r_addr_q <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc_q;
    w_addr_nxt  = r_addr_q;
    unique case (r_state)
      IDLE: begin
        if (br_taken) begin
          w_pc_nxt = br_target;
        end else if (!w_skid.valid) begin
          w_addr_nxt  = r_pc_q;
          w_pc_nxt    = next_pc(r_pc_q);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_xfer) begin
          if (br_taken) begin
            // Response is stale; reissue straight at the target.
            w_addr_nxt = br_target;
            w_pc_nxt   = next_pc(br_target);
          end else if (w_to_skid) begin
            // Skid just filled: stop requesting until it drains.
            w_state_nxt = IDLE;
          end else begin
            w_addr_nxt = r_pc_q;
            w_pc_nxt   = next_pc(r_pc_q);
          end
        end else if (br_taken) begin
          // Request must stay stable; remember the target and drop the reply.
          w_pc_nxt    = br_target;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          if (br_taken) begin
            w_addr_nxt = br_target;
            w_pc_nxt   = next_pc(br_target);
          end else begin
            w_addr_nxt = r_pc_q;
            w_pc_nxt   = next_pc(r_pc_q);
          end
          w_state_nxt = BUSY;
        end else if (br_taken) begin
          w_pc_nxt = br_target;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- output slot: skid first, then new response, else bubble ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_q <= 1'b0;
      r_instr_q <= '0;
      r_cpc_q   <= '0;
      r_pc4_q   <= '0;
    end else if (br_taken) begin
      r_valid_q <= 1'b0;
    end else if (w_unload) begin
      r_valid_q <= 1'b1;
      r_instr_q <= w_skid.instr;
      r_cpc_q   <= w_skid.pc;
      r_pc4_q   <= next_pc(w_skid.pc);
    end else if (w_to_slot) begin
      // Also taken under stall when the slot holds a bubble.
      r_valid_q <= 1'b1;
      r_instr_q <= imem_rdata;
      r_cpc_q   <= r_addr_q;
      r_pc4_q   <= next_pc(r_addr_q);
    end else if (!stall) begin
      r_valid_q <= 1'b0;
    end
  end

  assign instruction = r_instr_q;
  assign currPC      = r_cpc_q;
  assign pc_plus4    = r_pc4_q;
  assign IF_ID_flush = !r_valid_q || br_taken;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetches;
  logic [31:0] r_perf_bubbles;

  // ---- saturating event counters ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetches <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_accept && (r_perf_fetches != '1)) r_perf_fetches <= r_perf_fetches + 32'd1;
      if (IF_ID_flush && (r_perf_bubbles != '1)) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetches = r_perf_fetches;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
